// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and bit-vector helpers for the multi-port register file.
package rf_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int MAX_REGS = 256;
  typedef logic [MAX_REGS-1:0] vec_t;
  function automatic vec_t onehot(input int addr);
    onehot = vec_t'(1) << addr;
  endfunction
  function automatic logic [8:0] popcount(input vec_t v);
    popcount = '0;
    for (int i = 0; i < MAX_REGS; i++) popcount = popcount + {8'b0, v[i]};
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking with busy lookup per read port.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  localparam int ADDR_W = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(NUM_REGS + 1)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADR,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADR,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_ADR,
  input  logic                     FLUSH,
  output logic [CNT_W-1:0]         PEND_CNT
);
  logic [NUM_REGS-1:0] pend, pend_next, clr, set;
  vec_t clr_w, set_w;
  always_comb begin
    clr_w = onehot(int'(WR_ADR));
    set_w = onehot(int'(ISSUE_ADR));
    clr = (WR_EN && WR_ADR != '0) ? clr_w[NUM_REGS-1:0] : '0;
    set = (ISSUE_EN && ISSUE_ADR != '0 && !FLUSH) ? set_w[NUM_REGS-1:0] : '0;
    // set is applied after clr so a newly issued producer outranks a same-cycle writeback
    pend_next = FLUSH ? '0 : (pend & ~clr) | set;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pend <= '0;
      PEND_CNT <= '0;
    end else begin
      pend <= pend_next;
      PEND_CNT <= CNT_W'(popcount(vec_t'(pend_next)));
    end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [ADDR_W-1:0] a;
    assign a = RD_ADR[g*ADDR_W +: ADDR_W];
    assign RD_BUSY[g] = pend[a] & ~clr[a];
  end
endmodule

// File: rtl/rf_mp_sb.sv
// rf_mp_sb: multi-read-port register file with write bypass and pending-write scoreboard.
module rf_mp_sb
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  localparam int ADDR_W = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(NUM_REGS + 1)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADR,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADR,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_ADR,
  input  logic                     FLUSH,
  output logic [CNT_W-1:0]         PEND_CNT
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic byp_en;
  assign byp_en = WR_EN & RST_N;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (WR_EN && WR_ADR != '0) begin
      regs[WR_ADR] <= WR_DATA;
    end
  // bypass is gated by reset so every port reads zero while reset is held
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = RD_ADR[g*ADDR_W +: ADDR_W];
    assign RD_DATA[g*DATA_W +: DATA_W] = (a == '0) ? '0 : (byp_en && WR_ADR == a) ? WR_DATA : regs[a];
  end
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) u_sb (
    .CLK(CLK),
    .RST_N(RST_N),
    .RD_ADR(RD_ADR),
    .RD_BUSY(RD_BUSY),
    .WR_EN(WR_EN),
    .WR_ADR(WR_ADR),
    .ISSUE_EN(ISSUE_EN),
    .ISSUE_ADR(ISSUE_ADR),
    .FLUSH(FLUSH),
    .PEND_CNT(PEND_CNT)
  );
endmodule

// File: doc/rf_mp_sb.md
# rf_mp_sb

Parametrised multi-read-port register file with integrated pending-write scoreboard for the 5-stage OTTER pipeline. It replaces the single-write, two-read, negedge-written register file. It adds:
- posedge writes with same-cycle write-to-read bypass;
- an asynchronous clear of all registers;
- per-register pending tracking that decode uses to generate hazard stalls.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, register count (power of two, ≥2); register 0 is hardwired zero.
- NUM_RD, 2, number of independent read ports (1–4).
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset; the polarity and synchronicity are fixed:
  - asynchronous, active-low;
  - clears all registers and all pending bits.
- RD_ADR  in  NUM_RD×ADDR_W  read address per port.
- RD_DATA  out  NUM_RD×DATA_W  read data per port (combinational).
- RD_BUSY  out  NUM_RD  addressed register has an outstanding producer.
- WR_EN  in  1  writeback strobe.
- WR_ADR  in  ADDR_W  writeback address.
- WR_DATA  in  DATA_W  writeback data.
- ISSUE_EN  in  1  an instruction with a destination register enters execute.
- ISSUE_ADR  in  ADDR_W  destination of the issuing instruction.
- FLUSH  in  1  discards all pending bits (branch/jump flush).
- PEND_CNT  out  $clog2(NUM_REGS+1)  registered count of pending registers.

## Operation
Write:
- On each rising edge with WR_EN=1 and WR_ADR≠0, reg[WR_ADR] ← WR_DATA.
- Writes to address 0 are discarded.

Read (per port i):
- If RD_ADR[i]=0, RD_DATA[i]=0.
- Else, if WR_EN=1 and WR_ADR=RD_ADR[i], RD_DATA[i]=WR_DATA (bypass).
- Else RD_DATA[i]=reg[RD_ADR[i]].

Scoreboard (pend[NUM_REGS-1:0], pend[0] constant 0):
- clr = WR_EN & WR_ADR≠0 ? onehot(WR_ADR) : 0.
- set = ISSUE_EN & ISSUE_ADR≠0 & !FLUSH ? onehot(ISSUE_ADR) : 0.
- pend_next = FLUSH ? 0 : (pend & ~clr) | set.
- When set and clr hit the same register in one cycle, set wins: a newer producer has issued.

Busy and count:
- RD_BUSY[i] = pend[RD_ADR[i]] & !(clr[RD_ADR[i]]). A same-cycle writeback unblocks the reader through the bypass.
- ISSUE in the current cycle does not assert RD_BUSY that cycle.
- PEND_CNT ← popcount(pend_next) every edge, so it always equals popcount(pend).
- FLUSH does not block the write path: WR_EN during FLUSH still updates the register.

## Timing
- Reset: all registers 0, pend 0, PEND_CNT 0, RD_BUSY 0, RD_DATA 0 for every address. Reset takes effect immediately on RST_N falling, independent of CLK.
- Reset mid-operation discards any write or issue in that cycle. The first update is on the first rising edge after RST_N returns high.
- Read latency 0 (combinational).
- A write is visible via bypass in its own cycle and from the array from the next cycle.
- Scoreboard latency 1: ISSUE at edge N sets RD_BUSY from cycle N+1.
- Writeback clears RD_BUSY combinationally in the writeback cycle, and pend from the next cycle.
- ISSUE to an already-pending register keeps it pending; PEND_CNT does not change.
- WR to a non-pending register is legal; the data is written and pend is unchanged.

## Structure
- Package rf_pkg holds:
  - default DATA_W/NUM_REGS/NUM_RD;
  - a function onehot(addr);
  - a function popcount(vec).
- Sub-module rf_scoreboard (pend register, set/clr/flush logic, PEND_CNT, busy lookup per port) is instantiated once.
- The top module holds the storage array, the write logic and the read/bypass muxes.

## Test plan
- Reset: drive RST_N low mid-cycle after writing reg[5]=0xDEADBEEF. Required: RD_DATA=0 immediately and PEND_CNT=0. After release, reading reg 5 returns 0.
- Bypass and zero register:
  - WR_EN=1, WR_ADR=7, WR_DATA=0x12345678 with RD_ADR[0]=7 → RD_DATA[0]=0x12345678 the same cycle.
  - WR_ADR=0, WR_DATA=0xFFFFFFFF, then read 0 → 0.
- Scoreboard lifecycle:
  - ISSUE 3 → next cycle RD_BUSY=1 on a port reading 3, PEND_CNT=1.
  - WR 3 with data 0xA5 → that cycle RD_BUSY=0 and RD_DATA=0xA5. Next cycle PEND_CNT=0.
- Simultaneous set/clear: reg 9 pending; ISSUE 9 and WR 9 in the same cycle → next cycle reg9 is written, RD_BUSY still 1, PEND_CNT unchanged.
- Flush: issue regs 1, 2, 4 → PEND_CNT=3. FLUSH together with ISSUE 6 and WR 2 (data 0x55) → next cycle PEND_CNT=0, reg 6 not pending, reg2=0x55.
- Parameter sweep: NUM_RD=4, NUM_REGS=16, DATA_W=64 with random writes, issues and reads checked against a scoreboard reference model for 10k cycles.
